// File: rtl/console_pkg.sv
// console_pkg
// Shared definitions for the text console write path: default screen
// geometry, the fill code, the control codes the writer interprets, the
// writer state encoding, the cursor command encoding and the (row,col)
// to character-VRAM address mapping.
// No ports (package).
package console_pkg;

  localparam int         DEF_COLS  = 60;
  localparam int         DEF_ROWS  = 17;
  localparam logic [7:0] DEF_BLANK = 8'h20;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    CLEAR,
    SCROLL_RD,
    SCROLL_WR,
    FILL
  } state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADV,
    CUR_LF,
    CUR_CR,
    CUR_BS,
    CUR_HOME
  } cur_cmd_t;

  // Character cell to linear VRAM address; computed at 11 bits so the
  // caller decides where to truncate.
  function automatic logic [10:0] vram_addr(input logic [4:0] row,
                                            input logic [5:0] col,
                                            input int         cols);
    return 11'(int'(row) * cols + int'(col));
  endfunction

endpackage

// File: rtl/console_cursor.sv
// console_cursor
// Holds the text cursor and applies one cursor command per cycle:
// advance after a printed character (with wrap to the next row), line
// feed, carriage return, backspace (no reverse wrap) and home.
// When a command would move the cursor below the last row the cursor
// stays on the last row at column 0 and scroll_req tells the writer to
// sweep VRAM up by one row.
// Ports:
//   PixelClk    clock
//   nRST        synchronous active-low reset, cursor to (0,0)
//   cmd         cursor command for this cycle
//   cur_col     cursor column (registered)
//   cur_row     cursor row (registered)
//   scroll_req  combinational: cmd in this cycle needs a scroll
module console_cursor
  import console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  cur_cmd_t   cmd,
  output logic [5:0] cur_col,
  output logic [4:0] cur_row,
  output logic       scroll_req
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  logic at_last_row;
  logic at_last_col;

  // A scroll is needed when a line feed, or an advance off the end of the
  // row, happens while the cursor already sits on the bottom row.
  always_comb begin
    at_last_row = (cur_row == LAST_ROW);
    at_last_col = (cur_col == LAST_COL);
    scroll_req  = at_last_row &&
                  ((cmd == CUR_LF) || ((cmd == CUR_ADV) && at_last_col));
  end

  // Cursor register. On the bottom row a wrap or line feed leaves the row
  // unchanged because the screen content moves up instead.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      cur_col <= '0;
      cur_row <= '0;
    end else begin
      case (cmd)
        CUR_ADV: begin
          if (at_last_col) begin
            cur_col <= '0;
            if (!at_last_row) cur_row <= cur_row + 5'd1;
          end else begin
            cur_col <= cur_col + 6'd1;
          end
        end
        CUR_LF: begin
          cur_col <= '0;
          if (!at_last_row) cur_row <= cur_row + 5'd1;
        end
        CUR_CR: cur_col <= '0;
        CUR_BS: if (cur_col != 6'd0) cur_col <= cur_col - 6'd1;
        CUR_HOME: begin
          cur_col <= '0;
          cur_row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// text_console_writer
// Write side of the LCD text console. Takes character codes from the CPU
// over a valid/ready handshake and writes them into character VRAM
// port A (the renderer reads port B). Interprets LF, CR, BS and FF,
// wraps at the end of a row, scrolls the screen up by sweeping VRAM and
// clears the screen on FF.
// Optional build macro CLEAR_ON_RESET_EN: when defined, the block runs a
// full clear sweep straight after reset so the screen starts blank; when
// undefined it goes directly to IDLE and VRAM keeps its contents.
// Ports:
//   PixelClk  clock
//   nRST      synchronous active-low reset
//   ch_valid  character byte valid
//   ch_data   character code
//   ch_ready  byte can be accepted this cycle (IDLE only)
//   v_ada     VRAM port-A address
//   v_dina    VRAM port-A write data
//   v_wea     VRAM port-A write enable
//   v_douta   VRAM port-A read data, valid one cycle after the address
//   cur_col   cursor column
//   cur_row   cursor row
//   busy      clear or scroll sweep in progress
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS  = DEF_COLS,
  parameter int         ROWS  = DEF_ROWS,
  parameter logic [7:0] BLANK = DEF_BLANK
) (
  input  logic       PixelClk,
  input  logic       nRST,
  input  logic       ch_valid,
  input  logic [7:0] ch_data,
  output logic       ch_ready,
  output logic [9:0] v_ada,
  output logic [7:0] v_dina,
  output logic       v_wea,
  input  logic [7:0] v_douta,
  output logic [5:0] cur_col,
  output logic [4:0] cur_row,
  output logic       busy
);

  localparam logic [10:0] ROW_STRIDE  = 11'(COLS);
  localparam logic [10:0] SCROLL_LAST = 11'((ROWS - 1) * COLS - 1);
  localparam logic [10:0] FILL_FIRST  = 11'((ROWS - 1) * COLS);
  localparam logic [10:0] SCREEN_LAST = 11'(ROWS * COLS - 1);

`ifdef CLEAR_ON_RESET_EN
  localparam logic CLEAR_AT_RESET = 1'b1;
`else
  localparam logic CLEAR_AT_RESET = 1'b0;
`endif

  state_t      state;
  logic [10:0] sweep_addr;
  logic [7:0]  dina_q;
  logic        clear_pending;
  logic        accept;
  logic        is_ctrl;
  logic        scroll_req;
  cur_cmd_t    cur_cmd;

  // Handshake decode and the cursor command for this cycle. Control codes
  // move the cursor on the acceptance edge; a printed character moves it
  // at the end of its PUT cycle, after the write address was taken.
  always_comb begin
    accept  = ch_valid && ch_ready;
    is_ctrl = (ch_data[7:5] == 3'b000);
    cur_cmd = CUR_NONE;
    if (accept) begin
      case (ch_data)
        CC_LF:   cur_cmd = CUR_LF;
        CC_CR:   cur_cmd = CUR_CR;
        CC_BS:   cur_cmd = CUR_BS;
        CC_FF:   cur_cmd = CUR_HOME;
        default: cur_cmd = CUR_NONE;
      endcase
    end else if (state == PUT) begin
      cur_cmd = CUR_ADV;
    end
  end

  console_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .PixelClk  (PixelClk),
    .nRST      (nRST),
    .cmd       (cur_cmd),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .scroll_req(scroll_req)
  );

  // Port-A read data only arrives in the SCROLL_WR cycle itself, so the
  // copy data is passed straight through there; every other write uses
  // the registered data.
  assign v_dina = (state == SCROLL_WR) ? v_douta : dina_q;

  // Writer FSM. Every accepted byte costs at least one cycle with
  // ch_ready low. Scroll alternates a read of the row below with a write
  // of the current cell, then fills the bottom row with BLANK. Sweeps end
  // exactly on their last address and drop back to IDLE the cycle after.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      state         <= IDLE;
      sweep_addr    <= '0;
      dina_q        <= '0;
      v_ada         <= '0;
      v_wea         <= 1'b0;
      busy          <= 1'b0;
      ch_ready      <= !CLEAR_AT_RESET;
      clear_pending <= CLEAR_AT_RESET;
    end else begin
      case (state)
        IDLE: begin
          v_wea    <= 1'b0;
          ch_ready <= 1'b1;
          if (clear_pending) begin
            clear_pending <= 1'b0;
            state         <= CLEAR;
            sweep_addr    <= '0;
            v_ada         <= '0;
            dina_q        <= BLANK;
            v_wea         <= 1'b1;
            busy          <= 1'b1;
            ch_ready      <= 1'b0;
          end else if (accept) begin
            ch_ready <= 1'b0;
            if (ch_data == CC_FF) begin
              state      <= CLEAR;
              sweep_addr <= '0;
              v_ada      <= '0;
              dina_q     <= BLANK;
              v_wea      <= 1'b1;
              busy       <= 1'b1;
            end else if ((ch_data == CC_LF) && scroll_req) begin
              state      <= SCROLL_RD;
              sweep_addr <= '0;
              v_ada      <= 10'(ROW_STRIDE);
              busy       <= 1'b1;
            end else if (!is_ctrl) begin
              state  <= PUT;
              v_ada  <= 10'(vram_addr(cur_row, cur_col, COLS));
              dina_q <= ch_data;
              v_wea  <= 1'b1;
            end
          end
        end

        PUT: begin
          v_wea <= 1'b0;
          if (scroll_req) begin
            state      <= SCROLL_RD;
            sweep_addr <= '0;
            v_ada      <= 10'(ROW_STRIDE);
            busy       <= 1'b1;
          end else begin
            state    <= IDLE;
            ch_ready <= 1'b1;
          end
        end

        CLEAR, FILL: begin
          if (sweep_addr == SCREEN_LAST) begin
            state    <= IDLE;
            v_wea    <= 1'b0;
            busy     <= 1'b0;
            ch_ready <= 1'b1;
          end else begin
            sweep_addr <= sweep_addr + 11'd1;
            v_ada      <= 10'(sweep_addr + 11'd1);
          end
        end

        SCROLL_RD: begin
          state <= SCROLL_WR;
          v_ada <= sweep_addr[9:0];
          v_wea <= 1'b1;
        end

        SCROLL_WR: begin
          if (sweep_addr == SCROLL_LAST) begin
            state      <= FILL;
            sweep_addr <= FILL_FIRST;
            v_ada      <= 10'(FILL_FIRST);
            dina_q     <= BLANK;
            v_wea      <= 1'b1;
          end else begin
            state      <= SCROLL_RD;
            sweep_addr <= sweep_addr + 11'd1;
            v_ada      <= 10'(sweep_addr + ROW_STRIDE + 11'd1);
            v_wea      <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          v_wea    <= 1'b0;
          busy     <= 1'b0;
          ch_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer
// Self-checking bench for text_console_writer. A behavioural screen model
// (flat array plus cursor) turns each accepted byte into the list of VRAM
// writes it must cause; those are queued and a monitor pops and compares
// them whenever the DUT asserts v_wea. Directed sequences cover the
// boundary cases, then a randomized byte stream runs against the model.
module tb_text_console_writer;

  localparam int COLS = 60;
  localparam int ROWS = 17;
  localparam int CELLS = COLS * ROWS;

  typedef struct packed {
    logic [9:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       PixelClk = 1'b0;
  logic       nRST     = 1'b0;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data  = 8'h00;
  logic       ch_ready;
  logic [9:0] v_ada;
  logic [7:0] v_dina;
  logic       v_wea;
  logic [7:0] v_douta = 8'h00;
  logic [5:0] cur_col;
  logic [4:0] cur_row;
  logic       busy;

  logic [7:0] ram     [0:1023];
  logic [7:0] ref_mem [0:1023];
  bit         ram_seeded = 1'b0;
  wr_t        exp_q[$];
  wr_t        exp_e;

  int     n_vec = 0;
  int     n_err = 0;
  int     model_row = 0;
  int     model_col = 0;
  int     busy_cnt = 0;
  int     last_busy_len = 0;
  bit     busy_seen = 1'b0;
  longint acc_time = 0;

  text_console_writer dut (
    .PixelClk(PixelClk),
    .nRST    (nRST),
    .ch_valid(ch_valid),
    .ch_data (ch_data),
    .ch_ready(ch_ready),
    .v_ada   (v_ada),
    .v_dina  (v_dina),
    .v_wea   (v_wea),
    .v_douta (v_douta),
    .cur_col (cur_col),
    .cur_row (cur_row),
    .busy    (busy)
  );

  always #5 PixelClk = ~PixelClk;

  // VRAM port A: registered read-first output, write on v_wea.
  always @(posedge PixelClk) begin
    if (!ram_seeded) begin
      for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
      ram_seeded = 1'b1;
    end
    v_douta <= ram[v_ada];
    if (v_wea) ram[v_ada] = v_dina;
  end

  // Busy run-length tracker, sampled on the active edge.
  always @(posedge PixelClk) begin
    if (busy) begin
      busy_cnt  = busy_cnt + 1;
      busy_seen = 1'b1;
    end else if (busy_cnt != 0) begin
      last_busy_len = busy_cnt;
      busy_cnt      = 0;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every DUT write must match the next expected one.
  always @(negedge PixelClk) begin
    if (nRST && v_wea) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %02h, expected no write", v_ada, v_dina);
      end else begin
        exp_e = exp_q.pop_front();
        checkOutput("write_addr", int'(v_ada), int'(exp_e.addr));
        checkOutput("write_data", int'(v_dina), int'(exp_e.data));
      end
    end
  end

  // ---------------- behavioural screen model ----------------
  task automatic push_wr(input int a, input logic [7:0] d);
    ref_mem[a] = d;
    exp_q.push_back('{addr: 10'(a), data: d});
  endtask

  task automatic model_scroll();
    for (int a = 0; a < (ROWS - 1) * COLS; a++) push_wr(a, ref_mem[a + COLS]);
    for (int a = (ROWS - 1) * COLS; a < CELLS; a++) push_wr(a, 8'h20);
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h0A) begin
      model_col = 0;
      if (model_row == ROWS - 1) model_scroll();
      else model_row++;
    end else if (b == 8'h0D) begin
      model_col = 0;
    end else if (b == 8'h08) begin
      if (model_col > 0) model_col--;
    end else if (b == 8'h0C) begin
      for (int a = 0; a < CELLS; a++) push_wr(a, 8'h20);
      model_row = 0;
      model_col = 0;
    end else if (b >= 8'h20) begin
      push_wr(model_row * COLS + model_col, b);
      model_col++;
      if (model_col == COLS) begin
        model_col = 0;
        if (model_row == ROWS - 1) model_scroll();
        else model_row++;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic waitIdle();
    int g = 0;
    while (ch_ready !== 1'b1 && g < 4000) begin
      @(negedge PixelClk);
      g++;
    end
    checkOutput("ready_return", int'(ch_ready === 1'b1), 1);
  endtask

  task automatic checkCursor(input string tag);
    checkOutput({tag, "_col"}, int'(cur_col), model_col);
    checkOutput({tag, "_row"}, int'(cur_row), model_row);
    checkOutput({tag, "_busy"}, int'(busy), 0);
  endtask

  // Entered and left on a falling edge. With wait_done=0, ch_valid is
  // left high so the next call keeps the request asserted.
  task automatic applyStimulus(input logic [7:0] b, input bit wait_done);
    int g = 0;
    ch_valid = 1'b1;
    ch_data  = b;
    while (ch_ready !== 1'b1 && g < 4000) begin
      @(negedge PixelClk);
      g++;
    end
    if (ch_ready !== 1'b1) begin
      checkOutput("accept_timeout", int'(ch_ready), 1);
      ch_valid = 1'b0;
      return;
    end
    @(posedge PixelClk);
    acc_time = $time;
    model_byte(b);
    @(negedge PixelClk);
    checkOutput("ready_gap", int'(ch_ready), 0);
    if (wait_done) begin
      ch_valid = 1'b0;
      waitIdle();
      checkCursor("cursor");
    end
  endtask

  task automatic doReset();
    ch_valid = 1'b0;
    nRST     = 1'b0;
    @(negedge PixelClk);
    checkOutput("rst_wea", int'(v_wea), 0);
    checkOutput("rst_ada", int'(v_ada), 0);
    checkOutput("rst_dina", int'(v_dina), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_col", int'(cur_col), 0);
    checkOutput("rst_row", int'(cur_row), 0);
`ifdef CLEAR_ON_RESET_EN
    checkOutput("rst_ready", int'(ch_ready), 0);
`else
    checkOutput("rst_ready", int'(ch_ready), 1);
`endif
    @(negedge PixelClk);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) ref_mem[i] = ram[i];
    model_row = 0;
    model_col = 0;
    nRST = 1'b1;
`ifdef CLEAR_ON_RESET_EN
    model_byte(8'h0C);
    @(negedge PixelClk);
    waitIdle();
`endif
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [7:0] c;
    r = $urandom_range(0, 99);
    if (r < 72) return 8'($urandom_range(32, 255));
    if (r < 79) return 8'h0A;
    if (r < 85) return 8'h0D;
    if (r < 91) return 8'h08;
    if (r < 93) return 8'h0C;
    c = 8'($urandom_range(0, 31));
    if (c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C) c = 8'h07;
    return c;
  endfunction

  // Hard stop if the flow ever stalls beyond every per-wait bound.
  initial begin
    #950000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 95000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequences then randomized traffic.
  initial begin
    longint t0;
    int bad;
    repeat (2) @(negedge PixelClk);
    doReset();

    $display("[TB] single character at home");
    applyStimulus(8'h41, 1);

    $display("[TB] form feed with a queued byte");
    applyStimulus(8'h0C, 0);
    t0 = acc_time;
    applyStimulus(8'h5A, 1);
    checkOutput("ff_hold_cycles", int'((acc_time - t0) / 10), 1021);
    @(negedge PixelClk);
    checkOutput("clear_busy_len", last_busy_len, 1020);

    $display("[TB] row wrap without scroll");
    applyStimulus(8'h0D, 1);
    applyStimulus(8'h0A, 1);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h31, 1);
    for (int i = 0; i < COLS - 1; i++) applyStimulus(8'($urandom_range(32, 255)), 1);
    checkOutput("pre_wrap_col", int'(cur_col), 59);
    busy_seen = 1'b0;
    applyStimulus(8'h42, 1);
    @(negedge PixelClk);
    checkOutput("wrap_no_busy", int'(busy_seen), 0);

    $display("[TB] BS/CR/BEL at column 0");
    applyStimulus(8'h0A, 1);
    applyStimulus(8'h0A, 1);
    applyStimulus(8'h08, 1);
    applyStimulus(8'h0D, 1);
    applyStimulus(8'h07, 1);

    $display("[TB] wrap on bottom row triggers scroll");
    for (int i = 0; i < 11; i++) applyStimulus(8'h0A, 1);
    for (int i = 0; i < COLS - 1; i++) applyStimulus(8'($urandom_range(32, 255)), 1);
    applyStimulus(8'h43, 1);
    @(negedge PixelClk);
    checkOutput("scroll_busy_len", last_busy_len, 1980);
    bad = 0;
    for (int i = 0; i < COLS; i++) if (ram[i] !== 8'h31) bad++;
    checkOutput("row0_after_scroll_bad", bad, 0);
    bad = 0;
    for (int i = (ROWS - 1) * COLS; i < CELLS; i++) if (ram[i] !== 8'h20) bad++;
    checkOutput("row16_blank_bad", bad, 0);

    $display("[TB] line feed on bottom row");
    applyStimulus(8'h0A, 1);
    @(negedge PixelClk);
    checkOutput("lf_scroll_busy_len", last_busy_len, 1980);
    checkOutput("pending_writes", exp_q.size(), 0);

    $display("[TB] reset in the middle of a scroll");
    applyStimulus(8'h0A, 0);
    ch_valid = 1'b0;
    repeat (500) @(negedge PixelClk);
    doReset();

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) applyStimulus(rand_byte(), 1);

    repeat (4) @(negedge PixelClk);
    checkOutput("final_pending_writes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
